// File: rtl/seq_soma_pkg.sv
// Shared definitions for the nibble-serial adder sequencer.
//   state_t : FSM encoding (IDLE, SOMA, FIM)
//   NIB_W   : width of one nibble slice handled per cycle
//   clog2   : counter width helper, never returns less than 1
package seq_soma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SOMA = 2'd1,
    FIM  = 2'd2
  } state_t;

  localparam int NIB_W = 4;

  // A single-nibble configuration still needs a 1-bit counter to exist.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/somador_4bits.sv
// 4-bit combinational ripple adder.
//   A, B : 4-bit addends
//   Cin  : carry in
//   S    : 4-bit sum
//   Cout : carry out
module somador_4bits (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    S    = '0;
    c[0] = Cin;
    for (int i = 0; i < 4; i++) begin
      S[i]     = A[i] ^ B[i] ^ c[i];
      c[i + 1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
  end

  assign Cout = c[4];

endmodule

// File: rtl/seq_soma_16b.sv
// Wide adder built by time-multiplexing one 4-bit adder, one nibble per clock.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : upstream handshake; A, B, Cin captured on acceptance
//   out_valid / out_ready : downstream handshake; S, Cout held until taken
//   busy                : high whenever the FSM is not in IDLE
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// SOMA  | adding nibble cnt, carry kept in carry_q
// FIM   | result valid, waiting for out_ready
module seq_soma_16b
  import seq_soma_pkg::*;
#(
  parameter int N_NIB = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NIB_W*N_NIB-1:0] A,
  input  logic [NIB_W*N_NIB-1:0] B,
  input  logic                   Cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NIB_W*N_NIB-1:0] S,
  output logic                   Cout,
  output logic                   busy
);

  localparam int W  = NIB_W * N_NIB;
  localparam int CW = clog2(N_NIB);

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, b_q;
  logic            carry_q;
  logic [CW-1:0]   cnt;
  logic [NIB_W-1:0] nib_a, nib_b, nib_s;
  logic            nib_cout;
  logic            accept, last;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == FIM);
  assign busy      = (state_q != IDLE);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == CW'(N_NIB - 1));

  // Nibble select written as a decode so the counter never indexes out of range.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < N_NIB; i++) begin
      if (cnt == CW'(i)) begin
        nib_a = a_q[i*NIB_W +: NIB_W];
        nib_b = b_q[i*NIB_W +: NIB_W];
      end
    end
  end

  somador_4bits u_add (
    .A    (nib_a),
    .B    (nib_b),
    .Cin  (carry_q),
    .S    (nib_s),
    .Cout (nib_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SOMA;
      SOMA:    if (last) state_d = FIM;
      FIM:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      S       <= '0;
      Cout    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= A;
            b_q     <= B;
            carry_q <= Cin;
            cnt     <= '0;
            S       <= '0;
          end
        end
        SOMA: begin
          for (int i = 0; i < N_NIB; i++) begin
            if (cnt == CW'(i)) S[i*NIB_W +: NIB_W] <= nib_s;
          end
          carry_q <= nib_cout;
          if (last) Cout <= nib_cout;
          else      cnt  <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_soma_16b.sv
// Self-checking bench for seq_soma_16b (N_NIB=4): expected sums are pushed
// to a queue on acceptance and popped when the result handshake occurs.
module tb_seq_soma_16b;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] s;
  logic        cout;
  logic        busy;

  int          checks;
  int          errors;
  logic [16:0] exp_q[$];

  seq_soma_16b #(.N_NIB(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .Cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (s),
    .Cout      (cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one operation for a single cycle; the DUT must be in IDLE.
  task automatic accept_op(input logic [15:0] x, input logic [15:0] y, input logic c);
    a        = x;
    b        = y;
    cin      = c;
    in_valid = 1'b1;
    exp_q.push_back({1'b0, x} + {1'b0, y} + {16'h0, c});
    tick();
    in_valid = 1'b0;
  endtask

  // Returns the number of edges after acceptance until out_valid is seen.
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({in_ready, out_valid, busy, cout, s} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL reset_values got rdy=%0b ov=%0b busy=%0b cout=%0b s=%h want 1 0 0 0 0000",
               in_ready, out_valid, busy, cout, s);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sums();
    logic [15:0] va[3] = '{16'h0002, 16'hFFFF, 16'hAAAA};
    logic [15:0] vb[3] = '{16'h0001, 16'h0001, 16'hEEEE};
    logic        vc[3] = '{1'b0, 1'b0, 1'b1};
    int n;
    logic [16:0] e;
    for (int i = 0; i < 3; i++) begin
      accept_op(va[i], vb[i], vc[i]);
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL sum%0d_busy got rdy=%0b busy=%0b want 0 1", i, in_ready, busy);
      end
      wait_out(n);
      checks++;
      if (n != 4) begin
        errors++;
        $display("FAIL sum%0d_latency got %0d edges want 4", i, n);
      end
      if (!out_valid) begin
        exp_q.delete();
        return;
      end
      e = exp_q.pop_front();
      checks++;
      if ({cout, s} !== e) begin
        errors++;
        $display("FAIL sum%0d_result got %0b/%h want %0b/%h", i, cout, s, e[16], e[15:0]);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL sum%0d_release got rdy=%0b ov=%0b want 1 0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic [15:0] s0;
    logic        c0;
    logic [16:0] e;
    accept_op(16'h0F0F, 16'h0101, 1'b1);
    wait_out(n);
    s0 = s;
    c0 = cout;
    for (int k = 0; k < 3; k++) begin
      a        = 16'h5555;
      b        = 16'h3333;
      in_valid = 1'b1;
      tick();
      checks++;
      if (s !== s0 || cout !== c0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got s=%h cout=%0b ov=%0b rdy=%0b want s=%h cout=%0b ov=1 rdy=0",
                 k, s, cout, out_valid, in_ready, s0, c0);
      end
    end
    in_valid = 1'b0;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h0;
    checks++;
    if ({cout, s} !== e) begin
      errors++;
      $display("FAIL bp_result got %0b/%h want %0b/%h", cout, s, e[16], e[15:0]);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ignored got busy=%0b ov=%0b rdy=%0b want 0 0 1", busy, out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [16:0] e;
    accept_op(16'h1234, 16'h4321, 1'b1);
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, cout, s} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL midrst_values got rdy=%0b ov=%0b busy=%0b cout=%0b s=%h want 1 0 0 0 0000",
               in_ready, out_valid, busy, cout, s);
    end
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midrst_stale%0d got ov=%0b busy=%0b want 0 0", k, out_valid, busy);
      end
    end
    accept_op(16'h0000, 16'h0000, 1'b0);
    wait_out(n);
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL midrst_latency got %0d edges want 4", n);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1FFFF;
    checks++;
    if ({cout, s} !== e) begin
      errors++;
      $display("FAIL midrst_result got %0b/%h want %0b/%h", cout, s, e[16], e[15:0]);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] oa[2] = '{16'h1234, 16'h8000};
    logic [15:0] ob[2] = '{16'h1111, 16'h8000};
    int acc_cyc[2];
    int n_acc;
    int n_res;
    int cyc;
    logic [16:0] e;
    logic [16:0] want[2] = '{17'h02345, 17'h10000};
    n_acc = 0;
    n_res = 0;
    cyc   = 0;
    a        = oa[0];
    b        = ob[0];
    cin      = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    while (n_res < 2 && cyc < 60) begin
      if (in_valid && in_ready) begin
        exp_q.push_back({1'b0, a} + {1'b0, b} + {16'h0, cin});
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        checks++;
        if ({cout, s} !== e || e !== want[n_res]) begin
          errors++;
          $display("FAIL b2b_result%0d got %0b/%h want %0b/%h", n_res, cout, s,
                   want[n_res][16], want[n_res][15:0]);
        end
        n_res++;
      end
      tick();
      cyc++;
      if (n_acc == 1) begin
        a = oa[1];
        b = ob[1];
      end else if (n_acc == 2) begin
        in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (n_res != 2) begin
      errors++;
      $display("FAIL b2b_timeout got %0d results want 2", n_res);
    end
    checks++;
    if (n_acc != 2 || acc_cyc[1] - acc_cyc[0] != 6) begin
      errors++;
      $display("FAIL b2b_spacing got acc=%0d gap=%0d want acc=2 gap=6", n_acc,
               (n_acc == 2) ? acc_cyc[1] - acc_cyc[0] : -1);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    test_reset();
    test_sums();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_soma_16b.md
# seq_soma_16b

Sequencer that performs a multi-nibble addition by time-multiplexing one `somador_4bits` instance. It adds two `4*N_NIB`-bit operands plus a carry-in, one nibble per clock, propagating the carry in a register between nibbles. It sits between an upstream producer and a downstream consumer. Both sides use a valid/ready handshake, so the narrow adder becomes a wide adder at a fraction of the area.

## Interface
- `N_NIB`, default 4: number of nibbles per operand. Operand width is `W = 4*N_NIB`. Legal range is 1..8.
- `clk` input, 1 bit: the only clock. Every register updates on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `in_valid` input, 1 bit: the upstream operands are valid.
- `in_ready` output, 1 bit: the block can accept an operation.
- `A` input, W bits: operand A, sampled on acceptance.
- `B` input, W bits: operand B, sampled on acceptance.
- `Cin` input, 1 bit: carry-in, sampled on acceptance.
- `out_valid` output, 1 bit: the result is valid.
- `out_ready` input, 1 bit: the downstream consumer takes the result.
- `S` output, W bits: the sum, registered.
- `Cout` output, 1 bit: the final carry-out, registered.
- `busy` output, 1 bit: high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE: `in_ready=1`.
  - SOMA: one nibble is added per cycle.
  - FIM: `out_valid=1`.
- Acceptance: `in_valid && in_ready` in IDLE.
  - Latch A and B into operand registers and Cin into the carry register.
  - Clear the nibble counter `cnt` and S.
  - Go to SOMA.
- SOMA, each cycle:
  - Drive the adder with `A[4*cnt+:4]`, `B[4*cnt+:4]` and the carry register.
  - Write the adder S into `S[4*cnt+:4]`.
  - Load the carry register from the adder Cout.
  - If `cnt==N_NIB-1`, load `Cout` from the adder Cout and go to FIM. Otherwise increment `cnt`.
- FIM:
  - Hold S and Cout stable.
  - On `out_ready`, go to IDLE.
  - While `out_ready` stays low, remain in FIM with all outputs unchanged.
- `in_ready` is low in SOMA and FIM. `in_valid` in those states is ignored, with no queuing.
- Arithmetic: `{Cout,S} = A + B + Cin`, modulo `2^(W+1)`. No signed overflow flag.
- `N_NIB=1`: SOMA lasts exactly one cycle.
- Reset values, in any state:
  - state = IDLE, `in_ready=1`, `out_valid=0`, `busy=0`.
  - `S=0`, `Cout=0`, `cnt=0`, carry register = 0, operand registers = 0.
- Reset mid-operation: the partial result is discarded and no `out_valid` pulse follows.

## Timing
- Accept at edge t. SOMA runs during cycles t+1..t+N_NIB. `out_valid` rises after the edge at t+N_NIB and is visible in cycle t+N_NIB+1.
- Latency is N_NIB+1 cycles, from the acceptance edge to the first `out_valid` cycle.
- Leaving FIM: `out_ready` sampled high at edge u gives IDLE with `in_ready=1` in cycle u+1.
- Minimum period between acceptances is N_NIB+2 cycles.
- All outputs are registered, except `in_ready`, `busy` and `out_valid`, which decode the state register. There is no combinational path from any input to any output.
- The adder is purely combinational inside one cycle. Its critical path is one 4-bit ripple plus the mux and decode.

## Structure
- Package `seq_soma_pkg`:
  - State enum: IDLE=2'd0, SOMA=2'd1, FIM=2'd2.
  - Constant `NIB_W=4`.
  - Counter width function `clog2(N_NIB)`, with a minimum of 1.
- Sub-module: exactly one existing `somador_4bits` instance with ports A, B, Cin, S, Cout. It is not modified.
- Nibble-select muxes, FSM, counter and result register live in the top module.

## Test plan
- 0x0002 + 0x0001, Cin=0:
  - S=0x0003, Cout=0.
  - `out_valid` in the 5th cycle after acceptance (N_NIB=4).
- 0xFFFF + 0x0001, Cin=0:
  - S=0x0000, Cout=1.
  - Carry ripples through all nibble cycles.
- 0xAAAA + 0xEEEE, Cin=1 -> S=0x9999, Cout=1.
- Backpressure: hold `out_ready=0` for 3 cycles in FIM.
  - S, Cout and `out_valid` stay stable.
  - `in_ready` stays 0.
  - A new `in_valid` during this time is ignored.
- Reset mid-operation: assert `rst_n=0` during the 2nd SOMA cycle.
  - All outputs return to reset values immediately.
  - After release, a fresh 0x0000 + 0x0000, Cin=0 gives S=0, Cout=0 with no stale `out_valid`.
- Back-to-back: hold `in_valid=1` and `out_ready=1` with two operations, 0x1234 + 0x1111 then 0x8000 + 0x8000.
  - Results are 0x2345/0, then 0x0000/1.
  - Acceptances are 6 cycles apart.
